// File: rtl/bcd_rtc_clock.sv
// ============================================================================
// Module   : bcd_rtc_clock
// Brief    : BCD HH:MM:SS time-of-day counter with prescaler, 12/24 h mode,
//            range-checked load and one-cycle event pulses.
//            Optional alarm compare enabled by defining RTC_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_rtc_clock #(
    parameter int CLK_DIV = 1,
    parameter bit MODE12  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       set_valid_i,
    input  logic [1:0] set_h10_i,
    input  logic [3:0] set_h1_i,
    input  logic [2:0] set_m10_i,
    input  logic [3:0] set_m1_i,
    input  logic [2:0] set_s10_i,
    input  logic [3:0] set_s1_i,
    input  logic       set_pm_i,
`ifdef RTC_ALARM_EN
    input  logic       alarm_set_i,
    input  logic [1:0] alarm_h10_i,
    input  logic [3:0] alarm_h1_i,
    input  logic [2:0] alarm_m10_i,
    input  logic [3:0] alarm_m1_i,
    input  logic       alarm_pm_i,
    output logic       alarm_hit_o,
`endif
    output logic [1:0] hour10_o,
    output logic [3:0] hour1_o,
    output logic [2:0] min10_o,
    output logic [3:0] min1_o,
    output logic [2:0] sec10_o,
    output logic [3:0] sec1_o,
    output logic       pm_o,
    output logic       sec_tick_o,
    output logic       day_wrap_o,
    output logic       set_err_o
);

    localparam int               C_PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [C_PRE_W-1:0] C_LAST  = C_PRE_W'(CLK_DIV - 1);
    localparam logic [1:0]       C_RST_H10 = MODE12 ? 2'd1 : 2'd0;
    localparam logic [3:0]       C_RST_H1  = MODE12 ? 4'd2 : 4'd0;

    logic [C_PRE_W-1:0] presc_q, presc_d;
    logic [1:0] hour10_q, hour10_d;
    logic [3:0] hour1_q,  hour1_d;
    logic [2:0] min10_q,  min10_d;
    logic [3:0] min1_q,   min1_d;
    logic [2:0] sec10_q,  sec10_d;
    logic [3:0] sec1_q,   sec1_d;
    logic       pm_q,     pm_d;
    logic       sec_tick_q, sec_tick_d;
    logic       day_wrap_q, day_wrap_d;
    logic       set_err_q,  set_err_d;

    logic       w_tick;
    logic       w_set_ok;
    logic       w_load;
    logic [1:0] w_adv_h10;
    logic [3:0] w_adv_h1;
    logic [2:0] w_adv_m10;
    logic [3:0] w_adv_m1;
    logic [2:0] w_adv_s10;
    logic [3:0] w_adv_s1;
    logic       w_adv_pm;
    logic       w_adv_wrap;

    // One-second advance of the current time, carry rippling from seconds up.
    always_comb begin
        w_adv_h10  = hour10_q;
        w_adv_h1   = hour1_q;
        w_adv_m10  = min10_q;
        w_adv_m1   = min1_q;
        w_adv_s10  = sec10_q;
        w_adv_s1   = sec1_q;
        w_adv_pm   = pm_q;
        w_adv_wrap = 1'b0;
        if (sec1_q != 4'd9) begin
            w_adv_s1 = sec1_q + 4'd1;
        end else begin
            w_adv_s1 = 4'd0;
            if (sec10_q != 3'd5) begin
                w_adv_s10 = sec10_q + 3'd1;
            end else begin
                w_adv_s10 = 3'd0;
                if (min1_q != 4'd9) begin
                    w_adv_m1 = min1_q + 4'd1;
                end else begin
                    w_adv_m1 = 4'd0;
                    if (min10_q != 3'd5) begin
                        w_adv_m10 = min10_q + 3'd1;
                    end else begin
                        w_adv_m10 = 3'd0;
                        if (MODE12) begin
                            if (hour10_q == 2'd1 && hour1_q == 4'd2) begin
                                w_adv_h10 = 2'd0;
                                w_adv_h1  = 4'd1;
                            end else if (hour10_q == 2'd1 && hour1_q == 4'd1) begin
                                w_adv_h1   = 4'd2;
                                w_adv_pm   = ~pm_q;
                                w_adv_wrap = pm_q;
                            end else if (hour1_q == 4'd9) begin
                                w_adv_h10 = 2'd1;
                                w_adv_h1  = 4'd0;
                            end else begin
                                w_adv_h1 = hour1_q + 4'd1;
                            end
                        end else begin
                            if (hour10_q == 2'd2 && hour1_q == 4'd3) begin
                                w_adv_h10  = 2'd0;
                                w_adv_h1   = 4'd0;
                                w_adv_wrap = 1'b1;
                            end else if (hour1_q == 4'd9) begin
                                w_adv_h10 = hour10_q + 2'd1;
                                w_adv_h1  = 4'd0;
                            end else begin
                                w_adv_h1 = hour1_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_set_ok = (set_s1_i <= 4'd9) && (set_m1_i <= 4'd9) && (set_h1_i <= 4'd9) &&
                   (set_s10_i <= 3'd5) && (set_m10_i <= 3'd5);
        if (MODE12) begin
            w_set_ok = w_set_ok && ((set_h10_i == 2'd0 && set_h1_i != 4'd0) ||
                                    (set_h10_i == 2'd1 && set_h1_i <= 4'd2));
        end else begin
            w_set_ok = w_set_ok && ((set_h10_i < 2'd2) ||
                                    (set_h10_i == 2'd2 && set_h1_i <= 4'd3));
        end
    end

    assign w_load = set_valid_i && w_set_ok;

    always_comb begin
        w_tick  = 1'b0;
        presc_d = presc_q;
        if (en_i) begin
            if (presc_q == C_LAST) begin
                presc_d = '0;
                w_tick  = 1'b1;
            end else begin
                presc_d = presc_q + C_PRE_W'(1);
            end
        end
        hour10_d   = hour10_q;
        hour1_d    = hour1_q;
        min10_d    = min10_q;
        min1_d     = min1_q;
        sec10_d    = sec10_q;
        sec1_d     = sec1_q;
        pm_d       = pm_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        set_err_d  = 1'b0;
        // A valid load wins over a coincident tick and restarts the second.
        if (w_load) begin
            presc_d  = '0;
            hour10_d = set_h10_i;
            hour1_d  = set_h1_i;
            min10_d  = set_m10_i;
            min1_d   = set_m1_i;
            sec10_d  = set_s10_i;
            sec1_d   = set_s1_i;
            pm_d     = MODE12 ? set_pm_i : 1'b0;
        end else begin
            set_err_d = set_valid_i;
            if (w_tick) begin
                hour10_d   = w_adv_h10;
                hour1_d    = w_adv_h1;
                min10_d    = w_adv_m10;
                min1_d     = w_adv_m1;
                sec10_d    = w_adv_s10;
                sec1_d     = w_adv_s1;
                pm_d       = w_adv_pm;
                sec_tick_d = 1'b1;
                day_wrap_d = w_adv_wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            hour10_q   <= C_RST_H10;
            hour1_q    <= C_RST_H1;
            min10_q    <= 3'd0;
            min1_q     <= 4'd0;
            sec10_q    <= 3'd0;
            sec1_q     <= 4'd0;
            pm_q       <= 1'b0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            hour10_q   <= hour10_d;
            hour1_q    <= hour1_d;
            min10_q    <= min10_d;
            min1_q     <= min1_d;
            sec10_q    <= sec10_d;
            sec1_q     <= sec1_d;
            pm_q       <= pm_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
            set_err_q  <= set_err_d;
        end
    end

`ifdef RTC_ALARM_EN
    logic [1:0] alarm_h10_q, alarm_h10_d;
    logic [3:0] alarm_h1_q,  alarm_h1_d;
    logic [2:0] alarm_m10_q, alarm_m10_d;
    logic [3:0] alarm_m1_q,  alarm_m1_d;
    logic       alarm_pm_q,  alarm_pm_d;
    logic       alarm_hit_q, alarm_hit_d;

    // Only a real advance onto HH:MM:00 fires; loads are excluded via w_load.
    always_comb begin
        alarm_h10_d = alarm_h10_q;
        alarm_h1_d  = alarm_h1_q;
        alarm_m10_d = alarm_m10_q;
        alarm_m1_d  = alarm_m1_q;
        alarm_pm_d  = alarm_pm_q;
        if (alarm_set_i) begin
            alarm_h10_d = alarm_h10_i;
            alarm_h1_d  = alarm_h1_i;
            alarm_m10_d = alarm_m10_i;
            alarm_m1_d  = alarm_m1_i;
            alarm_pm_d  = MODE12 ? alarm_pm_i : 1'b0;
        end
        alarm_hit_d = w_tick && !w_load &&
                      (w_adv_h10 == alarm_h10_q) && (w_adv_h1 == alarm_h1_q) &&
                      (w_adv_m10 == alarm_m10_q) && (w_adv_m1 == alarm_m1_q) &&
                      (w_adv_s10 == 3'd0) && (w_adv_s1 == 4'd0) &&
                      (w_adv_pm == alarm_pm_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_h10_q <= C_RST_H10;
            alarm_h1_q  <= C_RST_H1;
            alarm_m10_q <= 3'd0;
            alarm_m1_q  <= 4'd0;
            alarm_pm_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            alarm_h10_q <= alarm_h10_d;
            alarm_h1_q  <= alarm_h1_d;
            alarm_m10_q <= alarm_m10_d;
            alarm_m1_q  <= alarm_m1_d;
            alarm_pm_q  <= alarm_pm_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign alarm_hit_o = alarm_hit_q;
`endif

    assign hour10_o   = hour10_q;
    assign hour1_o    = hour1_q;
    assign min10_o    = min10_q;
    assign min1_o     = min1_q;
    assign sec10_o    = sec10_q;
    assign sec1_o     = sec1_q;
    assign pm_o       = pm_q;
    assign sec_tick_o = sec_tick_q;
    assign day_wrap_o = day_wrap_q;
    assign set_err_o  = set_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_rtc_clock.sv
// ============================================================================
// Module   : tb_bcd_rtc_clock
// Brief    : Directed scoreboard bench: 24 h / CLK_DIV=4 instance and
//            12 h / CLK_DIV=1 instance of bcd_rtc_clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_rtc_clock;

    logic        clk;
    logic        rst_n;
    logic        a_en, a_sv, b_en, b_sv, b_pm_in;
    logic [19:0] a_set, b_set;

    logic [1:0] a_h10, b_h10;
    logic [3:0] a_h1,  b_h1;
    logic [2:0] a_m10, b_m10;
    logic [3:0] a_m1,  b_m1;
    logic [2:0] a_s10, b_s10;
    logic [3:0] a_s1,  b_s1;
    logic       a_pm, a_tick, a_wrap, a_err;
    logic       b_pm, b_tick, b_wrap, b_err;

    logic [23:0] obs_a, obs_b;
    assign obs_a = {a_h10, a_h1, a_m10, a_m1, a_s10, a_s1, a_pm, a_tick, a_wrap, a_err};
    assign obs_b = {b_h10, b_h1, b_m10, b_m1, b_s10, b_s1, b_pm, b_tick, b_wrap, b_err};

    bcd_rtc_clock #(.CLK_DIV(4), .MODE12(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en_i(a_en), .set_valid_i(a_sv),
        .set_h10_i(a_set[19:18]), .set_h1_i(a_set[17:14]), .set_m10_i(a_set[13:11]),
        .set_m1_i(a_set[10:7]), .set_s10_i(a_set[6:4]), .set_s1_i(a_set[3:0]),
        .set_pm_i(1'b0),
        .hour10_o(a_h10), .hour1_o(a_h1), .min10_o(a_m10), .min1_o(a_m1),
        .sec10_o(a_s10), .sec1_o(a_s1), .pm_o(a_pm),
        .sec_tick_o(a_tick), .day_wrap_o(a_wrap), .set_err_o(a_err)
    );

    bcd_rtc_clock #(.CLK_DIV(1), .MODE12(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en_i(b_en), .set_valid_i(b_sv),
        .set_h10_i(b_set[19:18]), .set_h1_i(b_set[17:14]), .set_m10_i(b_set[13:11]),
        .set_m1_i(b_set[10:7]), .set_s10_i(b_set[6:4]), .set_s1_i(b_set[3:0]),
        .set_pm_i(b_pm_in),
        .hour10_o(b_h10), .hour1_o(b_h1), .min10_o(b_m10), .min1_o(b_m1),
        .sec10_o(b_s10), .sec1_o(b_s1), .pm_o(b_pm),
        .sec_tick_o(b_tick), .day_wrap_o(b_wrap), .set_err_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          sel;
        logic [23:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [19:0] tm(input int h10, input int h1, input int m10,
                                       input int m1, input int s10, input int s1);
        return {h10[1:0], h1[3:0], m10[2:0], m1[3:0], s10[2:0], s1[3:0]};
    endfunction

    function automatic logic [23:0] mk(input logic [19:0] t, input bit pm, input bit tick,
                                       input bit wrap, input bit err);
        return {t, pm, tick, wrap, err};
    endfunction

    task automatic push(input string tag, input bit sel, input logic [23:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [23:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.sel ? obs_b : obs_a;
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        a_en = 1'b0; a_sv = 1'b0; a_set = '0;
        b_en = 1'b0; b_sv = 1'b0; b_set = '0; b_pm_in = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        push("reset_a", 1'b0, mk(tm(0,0,0,0,0,0), 0, 0, 0, 0));
        push("reset_b", 1'b1, mk(tm(1,2,0,0,0,0), 0, 0, 0, 0));
        check_all();

        #10 rst_n = 1'b1;
        a_en = 1'b1;
        push("a_pre_3edges", 1'b0, mk(tm(0,0,0,0,0,0), 0, 0, 0, 0));
        cyc(3); check_all();
        push("a_first_tick", 1'b0, mk(tm(0,0,0,0,0,1), 0, 1, 0, 0));
        cyc(1); check_all();
        push("a_tick_pulse_end", 1'b0, mk(tm(0,0,0,0,0,1), 0, 0, 0, 0));
        cyc(1); check_all();
        push("a_second_tick", 1'b0, mk(tm(0,0,0,0,0,2), 0, 1, 0, 0));
        cyc(3); check_all();

        a_set = tm(2,3,5,9,5,8); a_sv = 1'b1;
        push("a_load_235958", 1'b0, mk(tm(2,3,5,9,5,8), 0, 0, 0, 0));
        cyc(1); check_all();
        a_sv = 1'b0;
        push("a_235959", 1'b0, mk(tm(2,3,5,9,5,9), 0, 1, 0, 0));
        cyc(4); check_all();
        push("a_day_wrap", 1'b0, mk(tm(0,0,0,0,0,0), 0, 1, 1, 0));
        cyc(4); check_all();
        push("a_wrap_pulse_end", 1'b0, mk(tm(0,0,0,0,0,0), 0, 0, 0, 0));
        cyc(1); check_all();

        a_set = tm(2,4,0,0,0,0); a_sv = 1'b1;
        push("a_err_hour24", 1'b0, mk(tm(0,0,0,0,0,0), 0, 0, 0, 1));
        cyc(1); check_all();
        a_sv = 1'b0;
        push("a_err_pulse_end", 1'b0, mk(tm(0,0,0,0,0,0), 0, 0, 0, 0));
        cyc(1); check_all();
        a_set = tm(0,0,6,0,0,0); a_sv = 1'b1;
        push("a_err_with_tick", 1'b0, mk(tm(0,0,0,0,0,1), 0, 1, 0, 1));
        cyc(1); check_all();
        a_sv = 1'b0;

        cyc(3);
        a_set = tm(1,2,3,4,5,6); a_sv = 1'b1;
        push("a_load_beats_tick", 1'b0, mk(tm(1,2,3,4,5,6), 0, 0, 0, 0));
        cyc(1); check_all();
        a_sv = 1'b0;

        cyc(2);
        a_set = tm(0,9,5,9,5,9); a_sv = 1'b1;
        push("a_load_midcount", 1'b0, mk(tm(0,9,5,9,5,9), 0, 0, 0, 0));
        cyc(1); check_all();
        a_sv = 1'b0;
        push("a_presc_cleared", 1'b0, mk(tm(0,9,5,9,5,9), 0, 0, 0, 0));
        cyc(1); check_all();
        push("a_h1_carry_10h", 1'b0, mk(tm(1,0,0,0,0,0), 0, 1, 0, 0));
        cyc(3); check_all();

        a_en = 1'b0;
        push("a_en_hold", 1'b0, mk(tm(1,0,0,0,0,0), 0, 0, 0, 0));
        cyc(6); check_all();
        a_en = 1'b1;
        push("a_en_resume", 1'b0, mk(tm(1,0,0,0,0,1), 0, 1, 0, 0));
        cyc(4); check_all();

        rst_n = 1'b0;
        #1;
        push("a_async_reset", 1'b0, mk(tm(0,0,0,0,0,0), 0, 0, 0, 0));
        push("b_async_reset", 1'b1, mk(tm(1,2,0,0,0,0), 0, 0, 0, 0));
        check_all();
        #3 rst_n = 1'b1;
        a_en = 1'b0;

        b_set = tm(1,1,5,9,5,9); b_pm_in = 1'b0; b_sv = 1'b1;
        push("b_load_115959am", 1'b1, mk(tm(1,1,5,9,5,9), 0, 0, 0, 0));
        cyc(1); check_all();
        b_sv = 1'b0; b_en = 1'b1;
        push("b_noon_pm", 1'b1, mk(tm(1,2,0,0,0,0), 1, 1, 0, 0));
        cyc(1); check_all();
        b_en = 1'b0;
        b_set = tm(1,2,5,9,5,9); b_pm_in = 1'b1; b_sv = 1'b1;
        push("b_load_125959pm", 1'b1, mk(tm(1,2,5,9,5,9), 1, 0, 0, 0));
        cyc(1); check_all();
        b_sv = 1'b0; b_en = 1'b1;
        push("b_12_to_01", 1'b1, mk(tm(0,1,0,0,0,0), 1, 1, 0, 0));
        cyc(1); check_all();
        b_en = 1'b0;
        b_set = tm(1,1,5,9,5,9); b_pm_in = 1'b1; b_sv = 1'b1;
        push("b_load_115959pm", 1'b1, mk(tm(1,1,5,9,5,9), 1, 0, 0, 0));
        cyc(1); check_all();
        b_sv = 1'b0; b_en = 1'b1;
        push("b_midnight_wrap", 1'b1, mk(tm(1,2,0,0,0,0), 0, 1, 1, 0));
        cyc(1); check_all();
        b_en = 1'b0;
        push("b_wrap_pulse_end", 1'b1, mk(tm(1,2,0,0,0,0), 0, 0, 0, 0));
        cyc(1); check_all();

        b_set = tm(0,0,3,0,0,0); b_pm_in = 1'b0; b_sv = 1'b1;
        push("b_err_hour00", 1'b1, mk(tm(1,2,0,0,0,0), 0, 0, 0, 1));
        cyc(1); check_all();
        b_set = tm(1,3,0,0,0,0);
        push("b_err_hour13", 1'b1, mk(tm(1,2,0,0,0,0), 0, 0, 0, 1));
        cyc(1); check_all();

        b_set = tm(0,9,5,9,5,9); b_pm_in = 1'b0; b_en = 1'b1;
        push("b_load_beats_tick", 1'b1, mk(tm(0,9,5,9,5,9), 0, 0, 0, 0));
        cyc(1); check_all();
        b_sv = 1'b0;
        push("b_09_to_10", 1'b1, mk(tm(1,0,0,0,0,0), 0, 1, 0, 0));
        cyc(1); check_all();
        b_en = 1'b0;
        cyc(1);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
